// File: rtl/tdm_rx_deframer_if.sv
// TDM receive bus: serial side (sck/ws/sd) in, deframed sample array plus pulses out.
// master = TDM source / DSP core side, slave = deframer.
interface tdm_rx_deframer_if #(
    parameter int N_CH      = 8,
    parameter int WORD_BITS = 36
);
    logic                              sck;
    logic                              ws;
    logic                              sd;
    logic [N_CH-1:0][WORD_BITS-1:0]    samples;
    logic                              start;
    logic                              frame_err;

    modport master (output sck, ws, sd, input samples, start, frame_err);
    modport slave  (input sck, ws, sd, output samples, start, frame_err);
endinterface

// File: rtl/tdm_rx_deframer.sv
// TDM serial deframer: one ws sync bit, then N_CH*SLOT_BITS data bits, delivered as a word array.
// Optional macro TDM_RX_ERRCNT_EN adds a saturating 16-bit err_count output.
module tdm_rx_deframer #(
    parameter int N_CH        = 8,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int WORD_BITS   = 36
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tdm_rx_deframer_if.slave     bus
`ifdef TDM_RX_ERRCNT_EN
    ,
    output logic [15:0]          err_count
`endif
);
    localparam int SHIFT = WORD_BITS - SAMPLE_BITS - 4;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BIT_W = $clog2(SLOT_BITS);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_SB  = BIT_W'(SAMPLE_BITS - 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t                          state;
    logic [1:0]                      sck_sync, ws_sync, sd_sync;
    logic                            sck_q, ws_prev, at_sync;
    logic [CH_W-1:0]                 ch_idx;
    logic [BIT_W-1:0]                bit_idx;
    logic [SAMPLE_BITS-2:0]          shreg;
    logic [N_CH-1:0][WORD_BITS-1:0]  shadow, samples_q;
    logic                            start_q, frame_err_q;

    logic                            bit_ev, ws_b, sd_b, ws_rise, last_bit;
    logic [SAMPLE_BITS-1:0]          sample_nxt;
    logic [WORD_BITS-1:0]            word_nxt;

    assign ws_b       = ws_sync[1];
    assign sd_b       = sd_sync[1];
    assign bit_ev     = sck_sync[1] & ~sck_q;
    assign ws_rise    = ws_b & ~ws_prev;
    assign last_bit   = (ch_idx == LAST_CH) && (bit_idx == LAST_BIT);
    assign sample_nxt = {shreg, sd_b};
    // Sign-extend to the full word, then left-justify leaving 4 headroom bits.
    assign word_nxt   = {{(WORD_BITS-SAMPLE_BITS){sample_nxt[SAMPLE_BITS-1]}}, sample_nxt} << SHIFT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HUNT;
            sck_sync    <= '0;
            ws_sync     <= '0;
            sd_sync     <= '0;
            sck_q       <= 1'b0;
            ws_prev     <= 1'b0;
            at_sync     <= 1'b0;
            ch_idx      <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            shadow      <= '0;
            samples_q   <= '0;
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sck_sync    <= {sck_sync[0], bus.sck};
            ws_sync     <= {ws_sync[0], bus.ws};
            sd_sync     <= {sd_sync[0], bus.sd};
            sck_q       <= sck_sync[1];
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (bit_ev) begin
                ws_prev <= ws_b;
                case (state)
                    HUNT: begin
                        if (ws_rise) begin
                            state   <= RECV;
                            at_sync <= 1'b0;
                            ch_idx  <= '0;
                            bit_idx <= '0;
                        end
                    end
                    RECV: begin
                        // start is only raised on the last data bit and errors only on other
                        // bits, so the two pulses can never coincide.
                        if (at_sync) begin
                            at_sync <= 1'b0;
                            if (ws_b) begin
                                ch_idx  <= '0;
                                bit_idx <= '0;
                            end else begin
                                frame_err_q <= 1'b1;
                                state       <= HUNT;
                            end
                        end else if (ws_rise && !last_bit) begin
                            frame_err_q <= 1'b1;
                            ch_idx      <= '0;
                            bit_idx     <= '0;
                        end else begin
                            if (bit_idx <= LAST_SB) shreg <= sample_nxt[SAMPLE_BITS-2:0];
                            if (bit_idx == LAST_SB) shadow[ch_idx] <= word_nxt;
                            if (bit_idx == LAST_BIT) begin
                                bit_idx <= '0;
                                if (ch_idx == LAST_CH) begin
                                    at_sync <= 1'b1;
                                    ch_idx  <= '0;
                                end else begin
                                    ch_idx <= ch_idx + 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                            if (last_bit) begin
                                samples_q <= shadow;
                                if (LAST_SB == LAST_BIT) samples_q[N_CH-1] <= word_nxt;
                                start_q <= 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.samples   = samples_q;
    assign bus.start     = start_q;
    assign bus.frame_err = frame_err_q;

`ifdef TDM_RX_ERRCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_count <= '0;
        else if (frame_err_q && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_tdm_rx_deframer.sv
// Scoreboard bench for tdm_rx_deframer: frames are queued as expected word arrays when sent
// and popped on each start pulse; framing-error and reset cases are checked by pulse counts.
module tb_tdm_rx_deframer;
    localparam int N_CH = 8, SLOT_BITS = 32, SAMPLE_BITS = 24, WORD_BITS = 36;
    typedef logic [N_CH-1:0][WORD_BITS-1:0] frame_t;
    typedef logic [SAMPLE_BITS-1:0]         smp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    tdm_rx_deframer_if #(.N_CH(N_CH), .WORD_BITS(WORD_BITS)) bus ();
`ifdef TDM_RX_ERRCNT_EN
    logic [15:0] err_count;
`endif

    tdm_rx_deframer #(.N_CH(N_CH), .SLOT_BITS(SLOT_BITS), .SAMPLE_BITS(SAMPLE_BITS),
                      .WORD_BITS(WORD_BITS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus)
`ifdef TDM_RX_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int     n_tests = 0, n_fail = 0;
    int     start_cnt = 0, err_cnt = 0;
    frame_t exp_q[$];
    frame_t prev_samples = '0;

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_BITS-1:0] fmt(input smp_t s);
        return {{4{s[23]}}, s, 8'h00};
    endfunction

    task automatic push_exp(input smp_t v[N_CH]);
        frame_t e;
        for (int c = 0; c < N_CH; c++) e[c] = fmt(v[c]);
        exp_q.push_back(e);
    endtask

    // ws/sd change while sck is low; sck half periods are >= 2 clk with random jitter.
    task automatic send_bit(input logic w, input logic d);
        bus.ws = w;
        bus.sd = d;
        #($urandom_range(20, 27));
        bus.sck = 1'b1;
        #($urandom_range(20, 27));
        bus.sck = 1'b0;
    endtask

    task automatic send_data(input smp_t v[N_CH]);
        for (int c = 0; c < N_CH; c++)
            for (int b = 0; b < SLOT_BITS; b++)
                send_bit(1'b0, (b < SAMPLE_BITS) ? v[c][SAMPLE_BITS-1-b] : 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input smp_t v[N_CH]);
        send_bit(1'b1, 1'($urandom_range(0, 1)));
        send_data(v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.start) begin
                start_cnt++;
                chk("start_err_excl", 288'(bus.frame_err), 288'(0));
                if (exp_q.size() == 0) begin
                    chk("exp_queue_nonempty", 288'(exp_q.size()), 288'(1));
                end else begin
                    frame_t e;
                    e = exp_q.pop_front();
                    chk("samples", bus.samples, e);
                end
            end else if (bus.samples !== prev_samples) begin
                chk("samples_stable", bus.samples, prev_samples);
            end
            if (bus.frame_err) err_cnt++;
        end
        prev_samples = bus.samples;
    end

    initial begin
        smp_t v[N_CH];
        int s0, e0;
        frame_t pv;
        logic [WORD_BITS-1:0] w0, base;

        bus.sck = 1'b0;
        bus.ws  = 1'b0;
        bus.sd  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_samples", bus.samples, 288'(0));
        chk("rst_start", 288'(bus.start), 288'(0));
        chk("rst_err", 288'(bus.frame_err), 288'(0));
        @(negedge clk) reset_n = 1'b1;
        #($urandom_range(0, 9));

        // random frames, random phase
        for (int f = 0; f < 3; f++) begin
            foreach (v[i]) v[i] = smp_t'($urandom);
            push_exp(v);
            send_frame(v);
            idle(8);
        end
        chk("rand_starts", 288'(start_cnt), 288'(3));
        chk("rand_errs", 288'(err_cnt), 288'(0));

        // reset mid-frame
        s0 = start_cnt;
        send_bit(1'b1, 1'b0);
        for (int b = 0; b < 100; b++) send_bit(1'b0, 1'($urandom_range(0, 1)));
        #3 reset_n = 1'b0;
        #2;
        chk("midrst_samples", bus.samples, 288'(0));
        chk("midrst_start", 288'(bus.start), 288'(0));
        repeat (3) @(posedge clk);
        #($urandom_range(1, 9)) reset_n = 1'b1;
        for (int b = 0; b < 156; b++) send_bit(1'b0, 1'($urandom_range(0, 1)));
        idle(8);
        chk("midrst_nostart", 288'(start_cnt), 288'(s0));
        for (int f = 0; f < 2; f++) begin
            foreach (v[i]) v[i] = smp_t'($urandom);
            v[0] = 24'h7FFFFF;
            v[7] = 24'h800000;
            push_exp(v);
            send_frame(v);
            idle(8);
            chk("postrst_starts", 288'(start_cnt), 288'(s0 + f + 1));
        end
        chk("ch0_max", 288'(bus.samples[0]), 288'(36'h07FFFFF00));
        chk("ch7_min", 288'(bus.samples[7]), 288'(36'hF80000000));

        // ten consecutive frames, ch0 stepping by 0x100
        s0 = start_cnt;
        e0 = err_cnt;
        base = 36'($urandom_range(0, 24'h700000));
        w0 = '0;
        for (int f = 0; f < 10; f++) begin
            foreach (v[i]) v[i] = smp_t'($urandom);
            v[0] = smp_t'(base + 36'(f * 24'h100));
            push_exp(v);
            send_frame(v);
            idle(6);
            if (f > 0) chk("ch0_step", 288'(bus.samples[0] - w0), 288'(36'h10000));
            w0 = bus.samples[0];
        end
        chk("ten_starts", 288'(start_cnt), 288'(s0 + 10));
        chk("ten_errs", 288'(err_cnt), 288'(e0));

        // ws pulse injected at data index 100
        s0 = start_cnt;
        e0 = err_cnt;
        pv = bus.samples;
        send_bit(1'b1, 1'b0);
        for (int b = 0; b < 100; b++) send_bit(1'b0, 1'($urandom_range(0, 1)));
        send_bit(1'b1, 1'b0);
        idle(6);
        chk("inj_err", 288'(err_cnt), 288'(e0 + 1));
        chk("inj_nostart", 288'(start_cnt), 288'(s0));
        chk("inj_hold", bus.samples, pv);
        foreach (v[i]) v[i] = smp_t'($urandom);
        push_exp(v);
        send_data(v);
        idle(8);
        chk("realign_start", 288'(start_cnt), 288'(s0 + 1));
        chk("realign_errs", 288'(err_cnt), 288'(e0 + 1));

        // ws held low after the last bit
        s0 = start_cnt;
        e0 = err_cnt;
        foreach (v[i]) v[i] = smp_t'($urandom);
        push_exp(v);
        send_frame(v);
        send_bit(1'b0, 1'b0);
        idle(6);
        chk("lowws_start", 288'(start_cnt), 288'(s0 + 1));
        chk("lowws_err", 288'(err_cnt), 288'(e0 + 1));
        foreach (v[i]) v[i] = smp_t'($urandom);
        send_data(v);
        idle(8);
        chk("hunt_nostart", 288'(start_cnt), 288'(s0 + 1));
        foreach (v[i]) v[i] = smp_t'($urandom);
        push_exp(v);
        send_frame(v);
        idle(8);
        chk("hunt_recover", 288'(start_cnt), 288'(s0 + 2));
        chk("hunt_errs", 288'(err_cnt), 288'(e0 + 1));

`ifdef TDM_RX_ERRCNT_EN
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        e0 = err_cnt;
        send_bit(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 10; b++) send_bit(1'b0, 1'($urandom_range(0, 1)));
            send_bit(1'b1, 1'b0);
        end
        idle(6);
        chk("errcnt_three", 288'(err_count), 288'(3));
        chk("errcnt_pulses", 288'(err_cnt), 288'(e0 + 3));
        #2 reset_n = 1'b0;
        #2;
        chk("errcnt_rst", 288'(err_count), 288'(0));
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
`endif

        chk("exp_queue_drained", 288'(exp_q.size()), 288'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_rx_deframer.md
TDM_RX_DEFRAMER -- requirements
Module: tdm_rx_deframer

Interface
REQ-001 Parameter N_CH, default 8: channels per TDM frame and entries in samples.
REQ-002 Parameter SLOT_BITS, default 32: serial bits per channel slot.
REQ-003 Parameter SAMPLE_BITS, default 24: MSB-first two's-complement bits used per slot.
REQ-004 Parameter WORD_BITS, default 36: width of each samples entry.
REQ-005 clk  input  1: single system clock; all logic on its rising edge.
REQ-006 reset_n  input  1: asynchronous, active-low reset.
REQ-007 sck  input  1: external TDM bit clock, asynchronous to clk, at most clk/4.
REQ-008 ws  input  1: external frame sync, asynchronous to clk.
REQ-009 sd  input  1: external serial data, asynchronous to clk.
REQ-010 samples  output  N_CH x WORD_BITS: latest complete frame; feeds the DSP core input array.
REQ-011 start  output  1: one-clk pulse when samples holds a new frame; drives the DSP core start.
REQ-012 frame_err  output  1: one-clk pulse on a framing error.

Function
REQ-013 sck, ws and sd SHALL each pass a 2-flop synchronizer; a bit event is a 0->1 transition of synchronized sck.
REQ-014 ws and sd SHALL be sampled only on bit events.
REQ-015 FSM states: HUNT and RECV.
REQ-016 In HUNT, a bit event with ws=1 after a previous bit event with ws=0 SHALL enter RECV with bit index 0 at the next bit event (one-bit delay).
REQ-017 In RECV, each bit event SHALL shift sd into slot bit (index mod SLOT_BITS) of channel (index / SLOT_BITS), then increment the index.
REQ-018 Slot bits 0..SAMPLE_BITS-1 SHALL be captured; remaining slot bits SHALL be ignored.
REQ-019 A completed channel SHALL be written to a shadow register as sign_extend(sample) << (WORD_BITS-SAMPLE_BITS-4): 24-bit sample in bits [31:8], bits [35:32] = sign, bits [7:0] = 0.
REQ-020 On the bit event for index N_CH*SLOT_BITS-1, shadow SHALL be copied to samples and start SHALL pulse high on the next clk.
REQ-021 The DSP core therefore sees stable samples for a full frame; samples changes only in the same cycle start is high.
REQ-022 After the last index, ws=1 on the next bit event SHALL wrap the index to 0 and stay in RECV.
REQ-023 After the last index, ws=0 on the next bit event SHALL pulse frame_err and go to HUNT; the already delivered frame is kept.
REQ-024 A 0->1 ws transition in RECV at any index other than the last SHALL pulse frame_err and discard the partial frame; samples is unchanged and no start pulse is issued.
REQ-025 After REQ-024, the FSM SHALL realign with index 0 at the next bit event.
REQ-026 start and frame_err SHALL never be high in the same cycle; start wins when both would be issued.

Reset
REQ-027 reset_n low SHALL immediately clear samples, shadow, start, frame_err, the synchronizers, the index and the history of the previous ws value, and set state to HUNT.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release, no start pulse until a full frame is received following a fresh ws rise.

Configuration
REQ-029 With macro TDM_RX_ERRCNT_EN defined, an extra output err_count (16 bits) SHALL count frame_err pulses, saturate at 0xFFFF, and reset to 0.
REQ-030 Without TDM_RX_ERRCNT_EN, the err_count port and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset mid-frame, then two clean frames with ch0=0x7FFFFF and ch7=0x800000 -> no start before the first complete post-reset frame; then samples[0]=0x07FFFFF00, samples[7]=0xF80000000, one start per frame.
REQ-032 Ten consecutive frames with ch0 incrementing by 0x100 -> ten start pulses, one per frame; samples[0] steps by 0x10000; no frame_err.
REQ-033 ws pulse injected at index 100 -> frame_err for 1 clk; no start for that frame; samples holds the prior frame; the next aligned frame is delivered.
REQ-034 ws held low after the last bit -> start for the finished frame, then frame_err, HUNT, and no further start until ws rises again.
REQ-035 sck = clk/4 with random phase on sck/ws/sd relative to clk -> bit-exact samples for all 8 channels.
REQ-036 With TDM_RX_ERRCNT_EN defined, 3 injected errors -> err_count=3; after reset -> 0.
